// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: table geometry,
// entry layout, silent/idle output values and the sequencer state encoding.
package song_pkg;

  localparam int SONG_LEN = 32;
  localparam int ADDR_W   = 5;
  localparam int NOTE_W   = 5;
  localparam int BEAT_W   = 6;
  localparam int ENTRY_W  = NOTE_W + BEAT_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;
  localparam logic [BEAT_W-1:0] END_BEATS = '0;
  localparam logic [BEAT_W-1:0] IDLE_BDN  = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [BEAT_W-1:0] beats;
  } entry_t;

  function automatic logic is_end(entry_t e);
    return e.beats == END_BEATS;
  endfunction

endpackage

// File: rtl/song_if.sv
// Control/status bundle between the note-change controller (master) and the
// song sequencer (slave).
interface song_if;
  import song_pkg::*;

  // No valid/ready pair: start/stop/pause/loop_en are levels sampled on every
  // bclk edge, cp is a sub-period pulse that the sequencer latches on its own.
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic              cp;
  logic [NOTE_W-1:0] note_code;
  logic [BEAT_W-1:0] BDN;
  logic [ADDR_W-1:0] addr;
  logic              playing;
  logic              song_done;

  modport master (
    output start, stop, pause, loop_en, cp,
    input  note_code, BDN, addr, playing, song_done
  );

  modport slave (
    input  start, stop, pause, loop_en, cp,
    output note_code, BDN, addr, playing, song_done
  );

endinterface

// File: rtl/song_rom.sv
// Combinational song table: address -> {note, beats}. SONG_SEL picks the
// short demo tune (0) or a full-length scale with no end marker (1).
module song_rom
  import song_pkg::*;
#(
  parameter int SONG_SEL = 0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output entry_t            entry_o
);

  always_comb begin
    entry_o = '{note: NOTE_REST, beats: END_BEATS};
    if (SONG_SEL == 0) begin
      case (addr_i)
        5'd0:    entry_o = '{note: 5'd7, beats: 6'd4};
        5'd1:    entry_o = '{note: 5'd9, beats: 6'd2};
        default: entry_o = '{note: NOTE_REST, beats: END_BEATS};
      endcase
    end else begin
      // Every entry has 1..8 beats, so the song only ends by wrapping.
      entry_o.note  = addr_i + 5'd1;
      entry_o.beats = {3'b000, addr_i[2:0]} + 6'd1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Score reader: walks the song table one entry per cp pulse and presents the
// current note and beat count to the note-change controller.
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_SEL = 0
) (
  input  logic   bclk,
  input  logic   reset,
  song_if.slave  bus,
  output state_e state_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NOTE_W-1:0] note_q;
  logic [BEAT_W-1:0] bdn_q;
  logic              playing_q;
  logic              done_q;
  logic              cp_tog_q;
  logic              cp_seen_q;

  logic              cp_flag;
  logic              wrap_d;
  logic              at_end_d;
  logic [ADDR_W-1:0] next_addr_d;
  entry_t            cur_entry;
  entry_t            nxt_entry;
  entry_t            first_entry;

  // cp flag as a toggle pair: cp flips cp_tog_q, bclk copies it into
  // cp_seen_q. Their difference is "pulse pending"; every bclk edge consumes
  // it, so a pulse arriving outside PLAY is simply discarded.
  always_ff @(posedge bus.cp or posedge reset) begin
    if (reset) cp_tog_q <= 1'b0;
    else       cp_tog_q <= ~cp_tog_q;
  end

  assign cp_flag     = cp_tog_q ^ cp_seen_q;
  assign wrap_d      = (addr_q == ADDR_W'(SONG_LEN - 1));
  assign next_addr_d = wrap_d ? '0 : addr_q + ADDR_W'(1);
  assign at_end_d    = wrap_d || is_end(nxt_entry);

  song_rom #(.SONG_SEL(SONG_SEL)) u_rom_cur   (.addr_i(addr_q),      .entry_o(cur_entry));
  song_rom #(.SONG_SEL(SONG_SEL)) u_rom_nxt   (.addr_i(next_addr_d), .entry_o(nxt_entry));
  song_rom #(.SONG_SEL(SONG_SEL)) u_rom_first (.addr_i('0),          .entry_o(first_entry));

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      note_q    <= NOTE_REST;
      bdn_q     <= IDLE_BDN;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      cp_seen_q <= 1'b0;
    end else begin
      cp_seen_q <= cp_tog_q;
      done_q    <= 1'b0;
      if (bus.stop) begin
        state_q   <= ST_IDLE;
        addr_q    <= '0;
        note_q    <= NOTE_REST;
        bdn_q     <= IDLE_BDN;
        playing_q <= 1'b0;
      end else if (bus.start) begin
        addr_q <= '0;
        if (is_end(first_entry)) begin
          state_q   <= ST_DONE;
          note_q    <= NOTE_REST;
          bdn_q     <= IDLE_BDN;
          playing_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          state_q   <= ST_PLAY;
          note_q    <= first_entry.note;
          bdn_q     <= first_entry.beats;
          playing_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (bus.pause) begin
              state_q   <= ST_PAUSE;
              note_q    <= NOTE_REST;
              playing_q <= 1'b0;
            end else if (cp_flag) begin
              if (!at_end_d) begin
                addr_q <= next_addr_d;
                note_q <= nxt_entry.note;
                bdn_q  <= nxt_entry.beats;
              end else if (bus.loop_en) begin
                addr_q <= '0;
                note_q <= first_entry.note;
                bdn_q  <= first_entry.beats;
              end else begin
                state_q   <= ST_DONE;
                note_q    <= NOTE_REST;
                bdn_q     <= IDLE_BDN;
                playing_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (!bus.pause) begin
              state_q   <= ST_PLAY;
              note_q    <= cur_entry.note;
              bdn_q     <= cur_entry.beats;
              playing_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.note_code = note_q;
  assign bus.BDN       = bdn_q;
  assign bus.addr      = addr_q;
  assign bus.playing   = playing_q;
  assign bus.song_done = done_q;
  assign state_o       = state_q;

endmodule
